// File: rtl/caesar_pkg.sv
// caesar_pkg: shared types and modular helpers
// for the streaming Caesar cipher datapath.
package caesar_pkg;

  localparam int ALPHA_DEF = 26;
  localparam int SYM_W     = 5;

  typedef logic [SYM_W-1:0] sym_t;
  typedef logic [SYM_W:0]   wide_t;

  typedef struct packed {
    sym_t sym;
    sym_t key;
  } fifo_entry_t;

  function automatic sym_t mod_add(
    input sym_t  a,
    input sym_t  b,
    input wide_t alpha
  );
    wide_t s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= alpha) s = s - alpha;
    return s[SYM_W-1:0];
  endfunction

  function automatic sym_t mod_sub(
    input sym_t  a,
    input sym_t  b,
    input wide_t alpha
  );
    wide_t d;
    d = {1'b0, a} - {1'b0, b};
    if (d[SYM_W]) d = d + alpha;
    return d[SYM_W-1:0];
  endfunction

  function automatic sym_t key_reduce(
    input sym_t  k,
    input wide_t alpha
  );
    wide_t r;
    r = {1'b0, k};
    if (r >= alpha) r = r - alpha;
    return r[SYM_W-1:0];
  endfunction

endpackage

// File: rtl/caesar_fifo.sv
// caesar_fifo: synchronous FIFO of {symbol, key}
// pairs with occupancy count and full/empty flags.
module caesar_fifo
  import caesar_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  fifo_entry_t                wdata,
  output fifo_entry_t                rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fifo_entry_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // pointers and occupancy; pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/caesar_stream.sv
// caesar_stream: streaming Caesar cipher with
// loadable/rolling key and buffered output.
module caesar_stream
  import caesar_pkg::*;
#(
  parameter int ALPHA = ALPHA_DEF,
  parameter int SYM_W = caesar_pkg::SYM_W,
  parameter int DEPTH = 4
) (
  input  logic                       CLOCK_50,
  input  logic                       rst,
  input  logic                       key_load,
  input  logic [SYM_W-1:0]           key_in,
  input  logic                       encrypt,
  input  logic                       roll_en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SYM_W-1:0]           in_sym,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SYM_W-1:0]           out_sym,
  output logic [SYM_W-1:0]           out_key,
  output logic                       err,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [SYM_W-1:0]           key_cur
);

  localparam wide_t ALPHA_W = wide_t'(ALPHA);
  localparam sym_t  KEY_MAX = sym_t'(ALPHA - 1);

  sym_t        key_q;
  sym_t        cipher;
  logic        acc;
  logic        sym_ok;
  logic        push;
  logic        full;
  logic        empty;
  fifo_entry_t wdata;
  fifo_entry_t head;

  assign in_ready  = !full;
  assign acc       = in_valid && in_ready;
  assign sym_ok    = ({1'b0, in_sym} < ALPHA_W);
  assign push      = acc && sym_ok;
  assign cipher    = encrypt ? mod_add(in_sym, key_q, ALPHA_W)
                             : mod_sub(in_sym, key_q, ALPHA_W);
  assign wdata     = '{sym: cipher, key: key_q};
  assign out_valid = !empty;
  assign out_sym   = head.sym;
  assign out_key   = head.key;
  assign key_cur   = key_q;

  // key register: load beats roll; bad symbols never roll
  always_ff @(posedge CLOCK_50) begin
    if (rst)
      key_q <= '0;
    else if (key_load)
      key_q <= key_reduce(key_in, ALPHA_W);
    else if (push && roll_en)
      key_q <= (key_q == KEY_MAX) ? '0 : key_q + 1'b1;
  end

  // one-cycle error pulse for an out-of-range accept
  always_ff @(posedge CLOCK_50) begin
    if (rst) err <= 1'b0;
    else     err <= acc && !sym_ok;
  end

  caesar_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (CLOCK_50),
    .rst  (rst),
    .push (push),
    .pop  (out_ready),
    .wdata(wdata),
    .rdata(head),
    .count(count),
    .full (full),
    .empty(empty)
  );

endmodule

// File: tb/tb_caesar_stream.sv
// tb_caesar_stream: directed stimulus with a
// scoreboard queue checked at the output handshake.
module tb_caesar_stream;

  logic       CLOCK_50 = 1'b0;
  logic       rst = 1'b1;
  logic       key_load = 1'b0;
  logic [4:0] key_in = '0;
  logic       encrypt = 1'b1;
  logic       roll_en = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_sym = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [4:0] out_sym;
  logic [4:0] out_key;
  logic       err;
  logic [2:0] count;
  logic [4:0] key_cur;

  typedef struct {
    int sym;
    int key;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_push = 0;
  int   n_pop = 0;
  int   mkey = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  caesar_stream #(
    .ALPHA(26),
    .SYM_W(5),
    .DEPTH(4)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .key_load (key_load),
    .key_in   (key_in),
    .encrypt  (encrypt),
    .roll_en  (roll_en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sym   (in_sym),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sym  (out_sym),
    .out_key  (out_key),
    .err      (err),
    .count    (count),
    .key_cur  (key_cur)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_50);
  endtask

  task automatic load(input int k);
    key_load = 1'b1;
    key_in   = k[4:0];
    tick();
    key_load = 1'b0;
    mkey     = k % 26;
    chk("key_cur_load", key_cur, mkey);
  endtask

  task automatic send(input int s);
    int tries;
    int nk;
    bit done;
    tries    = 0;
    done     = 0;
    in_valid = 1'b1;
    in_sym   = s[4:0];
    while (!done) begin
      if (in_ready) begin
        nk = mkey;
        if (s < 26) begin
          if (encrypt)
            sb.push_back('{(s + mkey) % 26, mkey});
          else
            sb.push_back('{(s - mkey + 26) % 26, mkey});
          n_push++;
          if (roll_en) nk = (mkey + 1) % 26;
        end
        if (key_load) nk = key_in % 26;
        tick();
        mkey = nk;
        done = 1;
      end else if (tries == 20) begin
        chk("accept_timeout", in_ready, 1);
        done = 1;
      end else begin
        tries++;
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  // output monitor: pop scoreboard on each handshake
  always @(negedge CLOCK_50) begin
    exp_t e;
    #2;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", out_valid, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_out_sym", out_sym, e.sym);
        chk("sb_out_key", out_key, e.key);
        n_pop++;
      end
    end
  end

  initial begin
    // reset state
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_key_cur", key_cur, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_sym", out_sym, 0);
    chk("rst_out_key", out_key, 0);

    // encrypt wrap
    load(3);
    encrypt = 1'b1;
    send(23);
    chk("enc_valid", out_valid, 1);
    chk("enc_sym", out_sym, 0);
    chk("enc_key", out_key, 3);

    // decrypt borrow
    encrypt = 1'b0;
    send(1);
    chk("dec_sym", out_sym, 24);
    tick();

    // rolling key wrap
    load(25);
    encrypt = 1'b1;
    roll_en = 1'b1;
    send(0);
    send(0);
    send(0);
    chk("roll_key_cur", key_cur, 2);
    roll_en = 1'b0;
    repeat (3) tick();

    // key reduce and load/accept collision
    load(30);
    chk("reduce_key", key_cur, 4);
    key_load = 1'b1;
    key_in   = 5'd7;
    send(10);
    key_load = 1'b0;
    chk("coll_sym", out_sym, 14);
    chk("coll_key", out_key, 4);
    chk("coll_key_cur", key_cur, 7);
    repeat (2) tick();

    // backpressure and full
    out_ready = 1'b0;
    send(0);
    send(1);
    send(2);
    send(3);
    chk("full_in_ready", in_ready, 0);
    chk("full_count", count, 4);
    chk("full_head", out_sym, 7);
    in_valid = 1'b1;
    in_sym   = 5'd4;
    tick();
    chk("full_hold_count", count, 4);
    chk("full_hold_sym", out_sym, 7);
    chk("full_hold_key", out_key, 7);
    out_ready = 1'b1;
    send(4);
    repeat (8) tick();
    chk("drain_count", count, 0);
    chk("drain_valid", out_valid, 0);

    // invalid symbol then mid-stream reset
    out_ready = 1'b0;
    roll_en   = 1'b1;
    send(5);
    send(6);
    send(7);
    send(27);
    chk("bad_err", err, 1);
    chk("bad_count", count, 3);
    chk("bad_key_cur", key_cur, mkey);
    tick();
    chk("bad_err_clear", err, 0);
    rst      = 1'b1;
    key_load = 1'b1;
    key_in   = 5'd5;
    in_valid = 1'b1;
    in_sym   = 5'd2;
    tick();
    rst      = 1'b0;
    key_load = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    mkey     = 0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_key", key_cur, 0);
    chk("mid_rst_ready", in_ready, 1);
    roll_en   = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();

    chk("sb_empty", sb.size(), 0);
    chk("pop_total", n_pop, n_push - 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/caesar_stream.md
# caesar_stream

Parametrised, streaming Caesar-cipher engine and the successor to the switch/counter demo datapath. It accepts one alphabet index per handshake, then encrypts or decrypts it with a loadable shift key. An optional rolling-key mode advances the key after every symbol. Results are buffered in an output FIFO with valid/ready flow control, and the block sits between the input symbol source (switches, UART or counter) and the BCD/7-segment display path.

## Interface
- ALPHA, 26, alphabet size; legal symbols are 0..ALPHA-1
- SYM_W, 5, symbol/key width; require ALPHA <= 2^SYM_W <= 2*ALPHA
- DEPTH, 4, output FIFO depth; power of 2, >= 2
- CLOCK_50  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- key_load  in  1  load key_in into key register this cycle
- key_in  in  SYM_W  new shift key (reduced mod ALPHA on load)
- encrypt  in  1  1 = add key, 0 = subtract key; sampled per accepted symbol
- roll_en  in  1  rolling-key mode enable
- in_valid  in  1  input symbol valid
- in_ready  out  1  block can accept a symbol
- in_sym  in  SYM_W  input symbol
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head this cycle
- out_sym  out  SYM_W  ciphered symbol at FIFO head
- out_key  out  SYM_W  key used for the head symbol
- err  out  1  one-cycle pulse: accepted in_sym >= ALPHA
- count  out  $clog2(DEPTH+1)  FIFO occupancy
- key_cur  out  SYM_W  current key register value

## Operation
- Accept: in_valid && in_ready on a rising edge.
- in_ready = (count < DEPTH). There is no same-cycle pass-through when full.
- Encrypt: s = in_sym + key on SYM_W+1 bits; if s >= ALPHA then s -= ALPHA.
- Decrypt: d = in_sym - key; if it borrows, add ALPHA.
- Key load: if key_in >= ALPHA, store key_in - ALPHA; otherwise store key_in.
- Invalid symbol (in_sym >= ALPHA):
  - The symbol is consumed and dropped, with no FIFO write.
  - err pulses high the next cycle.
  - The key does not roll.
- Rolling key: after each valid accepted symbol with roll_en = 1, key = (key == ALPHA-1) ? 0 : key+1.
- Simultaneous key_load and accept:
  - The accepted symbol uses the old key.
  - key_load wins over roll, so the register takes the reduced key_in.
- FIFO:
  - Each valid accepted symbol writes the pair {ciphered symbol, key used}.
  - Pop on out_valid && out_ready. Read and write pointers wrap modulo DEPTH.
  - Simultaneous push and pop: count is unchanged, including at count = DEPTH (pop frees the slot; in_ready was already low, so no push can occur then).
  - Pop while empty is ignored.
- out_valid = (count != 0). out_sym and out_key show the head entry and hold stable while out_valid && !out_ready.
- Reset values:
  - count, key_cur, out_sym, out_key = 0
  - out_valid = 0, err = 0
  - in_ready = 1 in the first cycle after reset deasserts

## Timing
- Latency: a symbol accepted at edge N appears with out_valid high after edge N (visible in cycle N+1) when the FIFO was empty.
- Throughput: one symbol per cycle while out_ready stays high.
- key_load at edge N: key_cur shows the new value after edge N and applies to symbols accepted at edge N+1 onward.
- err is registered: it is high for exactly the one cycle after the offending accept.
- Reset mid-operation:
  - FIFO contents are discarded and pointers and count go to 0.
  - Any key_load or accept in the reset cycle is ignored.
- encrypt and roll_en are level inputs sampled only at accept edges. Changing them mid-stream affects only later symbols.

## Structure
- Package caesar_pkg:
  - ALPHA default constant.
  - sym_t typedef.
  - Functions mod_add, mod_sub and key_reduce, each single-subtract or single-add correction.
  - fifo_entry_t struct {sym_t sym; sym_t key}.
- Sub-module caesar_fifo: parametrised DEPTH synchronous FIFO of fifo_entry_t with count, full and empty.
- Top level: key register, cipher arithmetic, err register and handshake glue.

## Test plan
- Encrypt wrap: load key 3, encrypt = 1, send 23 -> out_sym 0, out_key 3, one cycle after accept.
- Decrypt borrow: key 3, encrypt = 0, send 1 -> out_sym 24.
- Rolling wrap: load key 25, roll_en = 1, send 0, 0, 0 -> outputs 25, 0, 1 with out_key 25, 0, 1; key_cur ends at 2.
- Key reduce and collision: key_in = 30 -> key_cur 4. Assert key_load = 7 together with accept of 10 under key 4 -> output 14, key_cur 7.
- Backpressure and full: DEPTH = 4, out_ready = 0, offer 5 symbols -> in_ready low after the 4th, count = 4. Release out_ready -> the 4 symbols drain in order, then the 5th is accepted.
- Invalid and reset: send 27 -> err pulse, count unchanged, key not rolled. Assert rst with count = 3 -> count 0, out_valid 0, key_cur 0 on the next cycle.
